// File: rtl/p2s_arb_pkg.sv
// Shared types and limits for the round-robin p2s arbiter.
package p2s_arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HDR  = 2'b01,
    PLD  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/p2s_arbiter_if.sv
// Requester and serializer-facing handshake signals of the p2s arbiter.
interface p2s_arbiter_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic [M-1:0]   req_valid;
  logic [M*N-1:0] req_data;
  logic [M-1:0]   req_ready;
  logic           par_valid;
  logic [N-1:0]   par_data;
  logic           par_ready;

  // master drives requests and the serializer's ready; slave is the arbiter
  modport master (
    output req_valid, req_data, par_ready,
    input  req_ready, par_valid, par_data
  );

  modport slave (
    input  req_valid, req_data, par_ready,
    output req_ready, par_valid, par_data
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational find-first-set over the request vector, starting at ptr and wrapping modulo M.
module rr_picker #(
  parameter int M  = 4,
  parameter int IW = $clog2(M)
) (
  input  logic [M-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [M-1:0][IW-1:0] cand;
  logic [M-1:0]         hit;

  // cand[gi] is the requester sitting gi places after ptr; ptr < M so one subtraction wraps it
  for (genvar gi = 0; gi < M; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum      = {1'b0, ptr} + (IW+1)'(gi);
    assign cand[gi] = (sum >= (IW+1)'(M)) ? IW'(sum - (IW+1)'(M)) : sum[IW-1:0];
    assign hit[gi]  = valid[cand[gi]];
  end

  always_comb begin
    any = |hit;
    idx = '0;
    for (int k = M - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/p2s_arbiter.sv
// Round-robin arbiter feeding one p2s serializer: per grant an optional header word
// (the requester index) followed by that requester's payload word.
module p2s_arbiter
  import p2s_arb_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 4,
  parameter int HDR_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  p2s_arbiter_if.slave          bus,
  output logic                  busy,
  output logic [$clog2(M)-1:0]  grant_id,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int IW = $clog2(M);

  if (M < 2 || M > MAX_REQ || M > (1 << N)) begin : g_param_check
    $error("p2s_arbiter: M must be 2..16 and fit in an N-bit header");
  end

  arb_state_e      state_reg, state_next;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   grant_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;

  rr_picker #(.M(M), .IW(IW)) u_picker (
    .valid (bus.req_valid),
    .ptr   (ptr_reg),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && pick_any) grant_reg <= pick_idx;
      // the served requester becomes lowest priority for the next arbitration
      if (state_reg == PLD && bus.par_ready) begin
        ptr_reg <= (grant_reg == IW'(M - 1)) ? '0 : grant_reg + 1'b1;
        if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.par_valid = 1'b0;
    bus.par_data  = '0;
    bus.req_ready = '0;
    case (state_reg)
      IDLE: begin
        if (pick_any) state_next = (HDR_EN != 0) ? HDR : PLD;
      end
      HDR: begin
        bus.par_valid = 1'b1;
        bus.par_data  = N'(grant_reg);
        if (bus.par_ready) state_next = PLD;
      end
      PLD: begin
        // payload passes straight through; the requester holds it until req_ready
        bus.par_valid = 1'b1;
        bus.par_data  = bus.req_data[grant_reg*N +: N];
        if (bus.par_ready) begin
          bus.req_ready[grant_reg] = 1'b1;
          state_next               = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_reg;
  assign frame_cnt = cnt_reg;

endmodule

// File: tb/tb_p2s_arbiter.sv
// Bench for p2s_arbiter: a header-enabled instance (A) and a payload-only, 2-bit counter instance (B),
// each fed by a behavioural p2s serializer model.
module tb_p2s_arbiter;
  localparam int N = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  p2s_arbiter_if #(.N(N), .M(M)) ifa ();
  p2s_arbiter_if #(.N(N), .M(M)) ifb ();

  logic        busy_a, busy_b;
  logic [1:0]  gid_a, gid_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  p2s_arbiter #(.N(N), .M(M), .HDR_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa.slave), .busy(busy_a), .grant_id(gid_a), .frame_cnt(cnt_a)
  );

  p2s_arbiter #(.N(N), .M(M), .HDR_EN(0), .CNT_W(2)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb.slave), .busy(busy_b), .grant_id(gid_b), .frame_cnt(cnt_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // serializer models: a word is taken when idle, then shifted out LSB-first while ser_ready is high
  int          bits_left [2];
  logic [7:0]  shreg [2];
  bit          ser_rdy [2];
  bit          stream_q [$];

  logic        obs_busy [2];
  logic        obs_pv [2];
  logic        obs_pr [2];
  logic [7:0]  obs_pd [2];
  logic [3:0]  obs_rr [2];
  logic [1:0]  obs_gid [2];
  logic [15:0] obs_cnt [2];

  typedef struct {
    logic [3:0]  rv;
    logic        exp_busy;
    logic        exp_pv;
    logic [7:0]  exp_pd;
    logic [3:0]  exp_rr;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tv [12];

  typedef struct {
    logic [7:0] w;
    bit         is_pld;
    int         g;
  } exp_w_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // one clock: par_ready from the models, sample at negedge, advance models, return at posedge+1
  task automatic cycle();
    ifa.par_ready = (bits_left[0] == 0);
    ifb.par_ready = (bits_left[1] == 0);
    @(negedge clk);
    obs_busy[0] = busy_a;          obs_busy[1] = busy_b;
    obs_pv[0]   = ifa.par_valid;   obs_pv[1]   = ifb.par_valid;
    obs_pr[0]   = ifa.par_ready;   obs_pr[1]   = ifb.par_ready;
    obs_pd[0]   = ifa.par_data;    obs_pd[1]   = ifb.par_data;
    obs_rr[0]   = ifa.req_ready;   obs_rr[1]   = ifb.req_ready;
    obs_gid[0]  = gid_a;           obs_gid[1]  = gid_b;
    obs_cnt[0]  = cnt_a;           obs_cnt[1]  = 16'(cnt_b);
    for (int d = 0; d < 2; d++) begin
      if (!rstn) begin
        bits_left[d] = 0;
      end else if (obs_pv[d] === 1'b1 && obs_pr[d] === 1'b1) begin
        shreg[d]     = obs_pd[d];
        bits_left[d] = N;
      end else if (bits_left[d] > 0 && ser_rdy[d]) begin
        if (d == 0) stream_q.push_back(shreg[d][0]);
        shreg[d]     = shreg[d] >> 1;
        bits_left[d] = bits_left[d] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < M; k++) begin
      if (v[(p + k) % M]) return (p + k) % M;
    end
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sbits;
    int          order_q [$];
    logic [3:0]  pend;
    logic [7:0]  rdata [4];
    int          mptr, mcnt, last_g, g, idx, pulses, last_pulse, b_words;
    bit          grant_pending, prev_stall, chk_cnt_next;
    logic [7:0]  prev_pd;
    exp_w_t      expq [$];
    exp_w_t      e;
    int          exp_cnt_b [5];

    ifa.req_valid = '0; ifa.req_data = '0; ifa.par_ready = 1'b1;
    ifb.req_valid = '0; ifb.req_data = '0; ifb.par_ready = 1'b1;
    bits_left[0] = 0; bits_left[1] = 0;
    shreg[0] = '0; shreg[1] = '0;
    ser_rdy[0] = 1'b1; ser_rdy[1] = 1'b1;

    // reset state of both instances
    rstn = 1'b0;
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(obs_busy[d]), 0);
      chk("rst_par_valid", 32'(obs_pv[d]), 0);
      chk("rst_par_data", 32'(obs_pd[d]), 0);
      chk("rst_req_ready", 32'(obs_rr[d]), 0);
      chk("rst_grant_id", 32'(obs_gid[d]), 0);
      chk("rst_frame_cnt", 32'(obs_cnt[d]), 0);
    end
    rstn = 1'b1;

    // single request on A: requester 2 with 8'hA5, cycle-by-cycle expectations
    tv[0] = '{4'b0100, 1'b0, 1'b0, 8'h00, 4'b0000, 16'd0};
    tv[1] = '{4'b0100, 1'b1, 1'b1, 8'h02, 4'b0000, 16'd0};
    for (int i = 2; i <= 9; i++) tv[i] = '{4'b0100, 1'b1, 1'b1, 8'hA5, 4'b0000, 16'd0};
    tv[10] = '{4'b0100, 1'b1, 1'b1, 8'hA5, 4'b0100, 16'd0};
    tv[11] = '{4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 16'd1};
    stream_q.delete();
    ifa.req_data = 32'h00A5_0000;
    for (int i = 0; i < 12; i++) begin
      ifa.req_valid = tv[i].rv;
      cycle();
      chk($sformatf("t1_busy[%0d]", i), 32'(obs_busy[0]), 32'(tv[i].exp_busy));
      chk($sformatf("t1_par_valid[%0d]", i), 32'(obs_pv[0]), 32'(tv[i].exp_pv));
      chk($sformatf("t1_par_data[%0d]", i), 32'(obs_pd[0]), 32'(tv[i].exp_pd));
      chk($sformatf("t1_req_ready[%0d]", i), 32'(obs_rr[0]), 32'(tv[i].exp_rr));
      chk($sformatf("t1_frame_cnt[%0d]", i), 32'(obs_cnt[0]), 32'(tv[i].exp_cnt));
    end
    chk("t1_grant_id", 32'(obs_gid[0]), 2);
    repeat (8) cycle();
    chk("t1_stream_len", stream_q.size(), 16);
    sbits = '0;
    for (int k = 0; k < 16 && k < stream_q.size(); k++) sbits[k] = stream_q[k];
    chk("t1_stream_bits", 32'(sbits), 32'h0000_A502);

    // reset while A is in the payload phase of requester 1
    ifa.req_valid = 4'b0010;
    ifa.req_data  = 32'h0000_5A00;
    repeat (3) cycle();
    chk("rst_mid_in_pld_pv", 32'(obs_pv[0]), 1);
    chk("rst_mid_in_pld_pd", 32'(obs_pd[0]), 32'h5A);
    chk("rst_mid_no_ready", 32'(obs_rr[0]), 0);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy_a), 0);
    chk("rst_async_pv", 32'(ifa.par_valid), 0);
    chk("rst_async_ready", 32'(ifa.req_ready), 0);
    cycle();
    chk("rst_mid_busy", 32'(obs_busy[0]), 0);
    chk("rst_mid_pv", 32'(obs_pv[0]), 0);
    chk("rst_mid_cnt", 32'(obs_cnt[0]), 0);
    rstn = 1'b1;

    // all four valid continuously: order 0,1,2,3,0 starting from the reset pointer
    ifa.req_valid = 4'b1111;
    ifa.req_data  = 32'h1312_1110;
    for (int c = 0; c < 120 && order_q.size() < 5; c++) begin
      cycle();
      if (obs_rr[0] != 4'b0000) begin
        chk("fair_onehot", $countones(obs_rr[0]), 1);
        idx = 0;
        for (int k = 0; k < M; k++) if (obs_rr[0][k]) idx = k;
        chk("fair_payload", 32'(obs_pd[0]), 32'(8'h10 + idx));
        order_q.push_back(idx);
      end
    end
    ifa.req_valid = 4'b0000;
    chk("fair_frames", order_q.size(), 5);
    for (int k = 0; k < 5 && k < order_q.size(); k++)
      chk($sformatf("fair_order[%0d]", k), order_q[k], k % M);
    cycle();
    chk("fair_idle_busy", 32'(obs_busy[0]), 0);
    chk("fair_cnt", 32'(obs_cnt[0]), 5);

    // randomized traffic with serializer stalls against the arbitration model
    pend = '0;
    for (int i = 0; i < M; i++) rdata[i] = '0;
    mptr = 1; mcnt = 5; last_g = 0;
    grant_pending = 1'b0; prev_stall = 1'b0; prev_pd = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < M; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 3) begin
          pend[i]  = 1'b1;
          rdata[i] = 8'($urandom);
        end
      end
      ifa.req_valid = pend;
      for (int i = 0; i < M; i++) ifa.req_data[i*8 +: 8] = rdata[i];
      ser_rdy[0] = ($urandom_range(0, 3) != 0);
      cycle();
      chk("rnd_cnt", 32'(obs_cnt[0]), mcnt);
      if (grant_pending) begin
        chk("rnd_latency", 32'(obs_pv[0]), 1);
        chk("rnd_gid", 32'(obs_gid[0]), last_g);
      end
      grant_pending = 1'b0;
      if (prev_stall) begin
        chk("rnd_hold_pv", 32'(obs_pv[0]), 1);
        chk("rnd_hold_pd", 32'(obs_pd[0]), 32'(prev_pd));
      end
      if (obs_busy[0] === 1'b0) begin
        chk("rnd_idle_pv", 32'(obs_pv[0]), 0);
        if (pend != 4'b0000) begin
          g = rr_pick(pend, mptr);
          expq.push_back('{8'(g), 1'b0, g});
          expq.push_back('{rdata[g], 1'b1, g});
          last_g = g;
          grant_pending = 1'b1;
        end
      end
      if (obs_pv[0] === 1'b1 && obs_pr[0] === 1'b1) begin
        if (expq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rnd_spurious_word: got %0h, expected no word", obs_pd[0]);
        end else begin
          e = expq.pop_front();
          chk("rnd_word", 32'(obs_pd[0]), 32'(e.w));
          chk("rnd_ready", 32'(obs_rr[0]), e.is_pld ? 32'(4'b0001 << e.g) : 32'd0);
          if (e.is_pld) begin
            pend[e.g] = 1'b0;
            mptr = (e.g + 1) % M;
            if (mcnt < 65535) mcnt++;
          end
        end
      end else begin
        chk("rnd_ready_quiet", 32'(obs_rr[0]), 0);
      end
      prev_stall = (obs_pv[0] === 1'b1) && (obs_pr[0] === 1'b0);
      prev_pd    = obs_pd[0];
    end

    // B: payload only, requester 1 held valid with 8'h3C, counter saturating at 3
    exp_cnt_b[0] = 1; exp_cnt_b[1] = 2; exp_cnt_b[2] = 3; exp_cnt_b[3] = 3; exp_cnt_b[4] = 3;
    ifb.req_valid = 4'b0010;
    ifb.req_data  = 32'h0000_3C00;
    pulses = 0; last_pulse = 0; b_words = 0; chk_cnt_next = 1'b0;
    for (int c = 0; c < 80 && pulses < 5; c++) begin
      cycle();
      if (chk_cnt_next) chk($sformatf("b_cnt[%0d]", pulses - 1), 32'(obs_cnt[1]), exp_cnt_b[pulses - 1]);
      chk_cnt_next = 1'b0;
      if (obs_pv[1] === 1'b1 && obs_pr[1] === 1'b1) begin
        b_words++;
        chk("b_word", 32'(obs_pd[1]), 32'h3C);
      end
      if (obs_rr[1] != 4'b0000) begin
        chk("b_ready", 32'(obs_rr[1]), 32'b0010);
        if (pulses == 0) chk("b_first_pulse", c, 1);
        else chk("b_gap", c - last_pulse, N + 1);
        last_pulse = c;
        pulses++;
        chk_cnt_next = 1'b1;
      end
    end
    ifb.req_valid = 4'b0000;
    cycle();
    if (chk_cnt_next) chk("b_cnt[4]", 32'(obs_cnt[1]), exp_cnt_b[4]);
    chk("b_pulses", pulses, 5);
    chk("b_words", b_words, 5);
    chk("b_idle_busy", 32'(obs_busy[1]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/p2s_arbiter.md
# p2s_arbiter

Round-robin arbiter that shares one `p2s` serializer among M parallel requesters in the safe-lock datapath. Each grant produces a frame on the serializer's parallel port: an optional header word carrying the requester index, then the requester's payload word. The block drives the serializer's `par_valid`/`par_data` and observes its `par_ready`. The `p2s` instance itself sits beside this block at the integration level.

## Interface
- `N`, 8: word width; must match the `p2s` `N`.
- `M`, 4: number of requesters, 2..16; must satisfy M ≤ 2**N.
- `HDR_EN`, 1: 1 = send a header word before each payload; 0 = payload only.
- `CNT_W`, 16: width of the frame counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  M  per-requester valid.
- `req_data`  in  M*N  packed payloads; requester i occupies bits [i*N +: N].
- `req_ready`  out  M  one-hot pulse on the cycle requester i's payload is taken.
- `par_valid`  out  1  to `p2s` `par_valid`.
- `par_data`  out  N  to `p2s` `par_data`.
- `par_ready`  in  1  from `p2s` `par_ready`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_id`  out  $clog2(M)  index of the current or last granted requester.
- `frame_cnt`  out  CNT_W  count of completed frames; saturates at all-ones.

## Operation
- FSM states: IDLE, HDR, PLD.
- IDLE
  - `par_valid`=0.
  - If any `req_valid` is high, pick the first valid requester searching from `ptr` upward, with wrap-around modulo M.
  - Latch that index into `grant_id`.
  - Go to HDR if HDR_EN=1, otherwise to PLD.
- HDR
  - `par_valid`=1; `par_data` = `grant_id` zero-extended to N bits.
  - On `par_valid && par_ready`, go to PLD.
- PLD
  - `par_valid`=1; `par_data` = `req_data[grant_id]`, taken combinationally from the requester.
  - On handshake: `req_ready[grant_id]`=1 for that cycle only, `ptr` ← (`grant_id`+1) mod M, `frame_cnt` increments unless saturated, and the FSM goes to IDLE.
- A requester must hold `req_valid` and `req_data` stable from assertion until its `req_ready` pulse. The arbiter does not re-check `req_valid` after the grant; dropping it mid-frame is a protocol violation.
- `req_ready` is 0 in every state except the PLD handshake cycle. At most one bit is ever set.
- Requests arriving while `busy`=1 wait. Arbitration happens only in IDLE.
- `par_data` is 0 in IDLE.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant_id`=0, `frame_cnt`=0, `par_valid`=0, `par_data`=0, `req_ready`=0, `busy`=0.
- Reset is asynchronous and applies mid-frame. The in-flight frame is abandoned and its requester receives no `req_ready`. Flushing a partially serialized word is the `p2s` block's own reset concern.
- Grant latency: `req_valid` first seen in IDLE at cycle t → `par_valid`=1 at cycle t+1.
- With `p2s` idle and `ser_ready` held 1:
  - The header is accepted at t+1.
  - The payload is accepted N+1 cycles after the header handshake.
  - IDLE is re-entered the cycle after the payload handshake.
- Minimum gap between frames: 1 IDLE cycle.
- Simultaneous requests are resolved only by `ptr`. The requester just served has lowest priority on the next grant.
- `frame_cnt` wraps never: it holds at 2**CNT_W−1.

## Structure
- Package `p2s_arb_pkg` holds:
  - the `arb_state_e` enum {IDLE, HDR, PLD}, with an explicit 2-bit encoding;
  - the constant `MAX_REQ`=16.
- Sub-module `rr_picker`: purely combinational find-first-set from `ptr` with wrap-around. It is parameterized by M and outputs `any` and `idx`.
- `p2s_arbiter` contains the FSM, `ptr`, `grant_id` and `frame_cnt` registers, and the output muxes.

## Test plan
- Reset then single request (N=8, M=4, HDR_EN=1): `req_valid[2]`=1, data 8'hA5 → `par_data` 8'h02 then 8'hA5; one `req_ready[2]` pulse; `frame_cnt`=1; serialized stream LSB-first is 0,1,0,0,0,0,0,0 then 1,0,1,0,0,1,0,1.
- All four requesters valid continuously → grant order 0,1,2,3,0; no requester is granted twice before the others are served.
- HDR_EN=0, requester 1 with data 8'h3C → only one word (8'h3C) reaches `p2s`; `req_ready[1]` pulses N+1 cycles after any preceding payload handshake.
- Serializer stalls (`ser_ready` toggled 0/1) → HDR and PLD hold `par_valid`=1 with stable `par_data` until `par_ready`; no lost or duplicated word.
- `rstn` asserted while in PLD → next cycle `busy`=0, `par_valid`=0, `ptr`=0; after release, requester 0 wins if valid.
- CNT_W=2, five frames → `frame_cnt` reads 1,2,3,3,3.
